// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin two-port arbiter/sequencer in front of datamemory,
//            with misalignment rejection and a registered one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last;
    logic                  r_sel;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic                  w_any;
    logic                  w_win;
    logic                  w_we;
    logic [2:0]            w_f3;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_mis;
    logic                  w_access;
    logic                  w_resp;
    logic [DATA_W-1:0]     w_rdata;

    // On a tie the requester that did not win last time takes the slot.
    assign w_any   = req0 | req1;
    assign w_win   = (req0 & req1) ? ~r_last : req1;
    assign w_we    = w_win ? we1      : we0;
    assign w_f3    = w_win ? funct3_1 : funct3_0;
    assign w_addr  = w_win ? addr1    : addr0;
    assign w_wdata = w_win ? wdata1   : wdata0;

    assign w_mis    = ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)) ||
                      ((r_f3[1:0] == 2'b01) && r_addr[0]);
    assign w_access = (r_state == c_ACCESS);
    assign w_resp   = (r_state == c_RESP);
    assign w_rdata  = (!r_we && !w_mis) ? rd : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_f3     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                c_ACCESS: begin
                    r_state <= c_RESP;
                    r_last  <= r_sel;
                    if (r_sel) begin
                        r_rdata1 <= w_rdata;
                    end else begin
                        r_rdata0 <= w_rdata;
                    end
                end
                default: begin
                    // IDLE and RESP both arbitrate, giving back-to-back accesses.
                    if (w_any) begin
                        r_state <= c_ACCESS;
                        r_sel   <= w_win;
                        r_we    <= w_we;
                        r_f3    <= w_f3;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt0 = w_access & ~r_sel;
    assign gnt1 = w_access &  r_sel;
    assign ack0 = w_resp   & ~r_sel;
    assign ack1 = w_resp   &  r_sel;
    assign err0 = ack0 & w_mis;
    assign err1 = ack1 & w_mis;

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

    assign MemRead  = w_access & ~r_we & ~w_mis;
    assign MemWrite = w_access &  r_we & ~w_mis;
    assign a        = r_addr;
    assign wd       = r_wdata;
    assign Funct3   = r_f3;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Randomized bench for dmem_arbiter against a transaction-level
//            reference model with its own shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req0, req1, we0, we1;
    logic [2:0]            funct3_0, funct3_1;
    logic [DM_ADDRESS-1:0] addr0, addr1;
    logic [DATA_W-1:0]     wdata0, wdata1;
    logic                  gnt0, gnt1, ack0, ack1, err0, err1;
    logic [DATA_W-1:0]     rdata0, rdata1;
    logic                  MemRead, MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [DATA_W-1:0]     rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .funct3_0(funct3_0), .funct3_1(funct3_1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd),
        .Funct3(Funct3), .rd(rd)
    );

    // Environment memory (stands in for datamemory) and the model's shadow copy.
    logic [7:0] env_mem [512];
    logic [7:0] ref_mem [512];

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic bit misaligned(input logic [2:0] f, input logic [8:0] ad);
        return (f[1:0] == 2'b10 && ad[1:0] != 2'b00) || (f[1:0] == 2'b01 && ad[0]);
    endfunction

    assign rd = fmt({env_mem[a + 9'd3], env_mem[a + 9'd2], env_mem[a + 9'd1], env_mem[a]}, Funct3);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side pending requests (held until the cycle after gnt).
    bit          pend [2];
    bit          p_we [2];
    logic [2:0]  p_f3 [2];
    logic [8:0]  p_ad [2];
    logic [31:0] p_wd [2];
    int          rand_pct = 0;

    // Reference model: which port is in its access / response slot this cycle.
    int          m_acc  = -1;
    int          m_resp = -1;
    bit          m_err  = 1'b0;
    bit          m_last = 1'b1;
    bit          m_rst_prev = 1'b1;
    logic [31:0] m_rd [2] = '{32'h0, 32'h0};
    bit          t_we;
    logic [2:0]  t_f3;
    logic [8:0]  t_ad;
    logic [31:0] t_wd;

    task automatic set_req(input int p, input bit we, input logic [2:0] f3,
                           input logic [8:0] ad, input logic [31:0] wdat);
        pend[p] = 1'b1; p_we[p] = we; p_f3[p] = f3; p_ad[p] = ad; p_wd[p] = wdat;
    endtask

    task automatic gen_req(input int p);
        logic [2:0] f3;
        logic [8:0] ad;
        bit         we;
        we = ($urandom_range(0, 2) == 0);
        f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        ad = 9'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) ad[0] = 1'b0;
            else if (f3[1:0] != 2'b00) ad[1:0] = 2'b00;
        end
        set_req(p, we, f3, ad, $urandom);
    endtask

    task automatic step(input bit do_rst);
        logic [31:0] data;
        int          w;
        int          nb;
        bit          mis;
        @(posedge clk);
        #1;
        mis = misaligned(t_f3, t_ad);
        chk_val("gnt0", 32'(gnt0), 32'(m_acc == 0));
        chk_val("gnt1", 32'(gnt1), 32'(m_acc == 1));
        chk_val("ack0", 32'(ack0), 32'(m_resp == 0));
        chk_val("ack1", 32'(ack1), 32'(m_resp == 1));
        chk_val("err0", 32'(err0), 32'(m_resp == 0 && m_err));
        chk_val("err1", 32'(err1), 32'(m_resp == 1 && m_err));
        chk_val("rdata0", rdata0, m_rd[0]);
        chk_val("rdata1", rdata1, m_rd[1]);
        chk_val("MemRead",  32'(MemRead),  32'(m_acc >= 0 && !t_we && !mis));
        chk_val("MemWrite", 32'(MemWrite), 32'(m_acc >= 0 &&  t_we && !mis));
        if (m_acc >= 0) begin
            chk_val("a", 32'(a), 32'(t_ad));
            chk_val("Funct3", 32'(Funct3), 32'(t_f3));
            if (t_we) chk_val("wd", wd, t_wd);
        end
        if (m_rst_prev) begin
            chk_val("a_rst", 32'(a), 32'h0);
            chk_val("wd_rst", wd, 32'h0);
            chk_val("Funct3_rst", 32'(Funct3), 32'h0);
        end

        reset = do_rst;
        for (int p = 0; p < 2; p++) begin
            if (m_resp == p) pend[p] = 1'b0;
            if (!pend[p] && $urandom_range(0, 99) < rand_pct) gen_req(p);
        end
        req0 = pend[0]; we0 = p_we[0]; funct3_0 = p_f3[0]; addr0 = p_ad[0]; wdata0 = p_wd[0];
        req1 = pend[1]; we1 = p_we[1]; funct3_1 = p_f3[1]; addr1 = p_ad[1]; wdata1 = p_wd[1];

        m_rst_prev = do_rst;
        if (do_rst) begin
            m_acc = -1; m_resp = -1; m_err = 1'b0; m_last = 1'b1;
            m_rd[0] = 32'h0; m_rd[1] = 32'h0;
        end else begin
            m_resp = m_acc;
            m_err  = 1'b0;
            if (m_acc >= 0) begin
                data = 32'h0;
                if (mis) begin
                    m_err = 1'b1;
                end else if (t_we) begin
                    nb = (t_f3[1:0] == 2'b00) ? 1 : (t_f3[1:0] == 2'b01) ? 2 : 4;
                    for (int i = 0; i < nb; i++) ref_mem[t_ad + 9'(i)] = t_wd[8*i +: 8];
                end else begin
                    data = fmt({ref_mem[t_ad + 9'd3], ref_mem[t_ad + 9'd2],
                                ref_mem[t_ad + 9'd1], ref_mem[t_ad]}, t_f3);
                end
                m_rd[m_acc] = data;
                m_last = (m_acc == 1);
                m_acc  = -1;
            end else if (pend[0] || pend[1]) begin
                w = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
                m_acc = w;
                t_we = p_we[w]; t_f3 = p_f3[w]; t_ad = p_ad[w]; t_wd = p_wd[w];
            end
        end

        // datamemory writes on the falling edge inside the access cycle.
        @(negedge clk);
        if (MemWrite) begin
            env_mem[a] = wd[7:0];
            if (Funct3[1:0] != 2'b00) env_mem[a + 9'd1] = wd[15:8];
            if (Funct3[1]) begin
                env_mem[a + 9'd2] = wd[23:16];
                env_mem[a + 9'd3] = wd[31:24];
            end
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        funct3_0 = '0; funct3_1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_we[p] = 1'b0; p_f3[p] = '0; p_ad[p] = '0; p_wd[p] = '0;
        end
        t_we = 1'b0; t_f3 = '0; t_ad = '0; t_wd = '0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 8'($urandom);
            env_mem[i] = ref_mem[i];
        end
        {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'hDEADBEEF;
        {env_mem[19], env_mem[18], env_mem[17], env_mem[16]} = 32'hDEADBEEF;

        step(1'b1);
        step(1'b1);

        // single word load
        set_req(0, 1'b0, 3'b010, 9'h010, 32'h0);
        repeat (4) step(1'b0);
        chk_val("lw_deadbeef", rdata0, 32'hDEADBEEF);

        // store from port 1, then load it back on port 0
        set_req(1, 1'b1, 3'b010, 9'h020, 32'h12345678);
        repeat (3) step(1'b0);
        chk_val("sw_rdata1", rdata1, 32'h0);
        set_req(0, 1'b0, 3'b010, 9'h020, 32'h0);
        repeat (4) step(1'b0);
        chk_val("lw_after_sw", rdata0, 32'h12345678);

        // misaligned word / half, then a byte that is never misaligned
        set_req(0, 1'b0, 3'b010, 9'h002, 32'h0);
        set_req(1, 1'b0, 3'b001, 9'h005, 32'h0);
        repeat (6) step(1'b0);
        set_req(0, 1'b0, 3'b000, 9'h003, 32'h0);
        repeat (4) step(1'b0);

        // reset during ACCESS, then the retried tie must go to requester 0
        set_req(0, 1'b0, 3'b010, 9'h010, 32'h0);
        set_req(1, 1'b0, 3'b010, 9'h020, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0);
            if (m_acc >= 0) found = 1'b1;
        end
        chk_val("access_reached", 32'(found), 32'h1);
        step(1'b1);
        repeat (6) step(1'b0);

        rand_pct = 100;
        repeat (300) step(1'b0);
        rand_pct = 40;
        repeat (600) step(1'b0);
        rand_pct = 10;
        repeat (200) step(1'b0);
        rand_pct = 0;
        repeat (6) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
